rs_select_wakeup: RTL and testbench

Parametrised reservation station for the P6-style out-of-order core, sitting between dispatch (ID + map table + ROB allocation) and the functional units. It holds up to RS_DEPTH in-flight instructions and captures operand values broadcast on N_CDB parallel CDB ports. Each cycle it issues one ready instruction, picking the oldest relative to the ROB head, with a valid/ready handshake to the FU. A full-flush squash input supports mispredict recovery.

---
 rtl/rs_select_wakeup.sv | 199 +++++++++++++++++++
 tb/tb_rs_select_wakeup.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_select_wakeup.sv
// Reservation station: captures operands from the CDB ports and picks one ready instruction per cycle.
// Among the ready instructions, the one with the smallest ROB-relative age is chosen.
module rs_select_wakeup #(
    parameter int RS_DEPTH = 8,
    parameter int N_CDB    = 2,
    parameter int TAG_W    = 5,
    parameter int DATA_W   = 32,
    parameter int INST_W   = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [INST_W-1:0]             disp_inst,
    input  logic [TAG_W-1:0]              disp_rob_idx,
    input  logic                          disp_rs1_ready,
    input  logic                          disp_rs2_ready,
    input  logic [TAG_W-1:0]              disp_rs1_tag,
    input  logic [TAG_W-1:0]              disp_rs2_tag,
    input  logic [DATA_W-1:0]             disp_rs1_value,
    input  logic [DATA_W-1:0]             disp_rs2_value,
    input  logic [N_CDB-1:0]              cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]        cdb_tag,
    input  logic [N_CDB*DATA_W-1:0]       cdb_value,
    input  logic [TAG_W-1:0]              rob_head_idx,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [INST_W-1:0]             iss_inst,
    output logic [TAG_W-1:0]              iss_rob_idx,
    output logic [DATA_W-1:0]             iss_rs1_value,
    output logic [DATA_W-1:0]             iss_rs2_value,
    output logic [$clog2(RS_DEPTH+1)-1:0] free_count
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RS_DEPTH+1);

    logic [RS_DEPTH-1:0] busy;
    logic [INST_W-1:0]   entry_inst      [RS_DEPTH];
    logic [TAG_W-1:0]    entry_rob       [RS_DEPTH];
    logic                entry_rs1_ready [RS_DEPTH];
    logic [TAG_W-1:0]    entry_rs1_tag   [RS_DEPTH];
    logic [DATA_W-1:0]   entry_rs1_value [RS_DEPTH];
    logic                entry_rs2_ready [RS_DEPTH];
    logic [TAG_W-1:0]    entry_rs2_tag   [RS_DEPTH];
    logic [DATA_W-1:0]   entry_rs2_value [RS_DEPTH];

    logic                wake1_hit   [RS_DEPTH];
    logic [DATA_W-1:0]   wake1_value [RS_DEPTH];
    logic                wake2_hit   [RS_DEPTH];
    logic [DATA_W-1:0]   wake2_value [RS_DEPTH];
    logic [TAG_W-1:0]    entry_age   [RS_DEPTH];
    logic [RS_DEPTH-1:0] eligible;

    logic                byp1_hit;
    logic [DATA_W-1:0]   byp1_value;
    logic                byp2_hit;
    logic [DATA_W-1:0]   byp2_value;

    logic [CNT_W-1:0]    busy_count;
    logic [IDX_W-1:0]    alloc_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_found;
    logic [TAG_W-1:0]    best_age;
    logic                issue_fire;
    logic                alloc_fire;

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            busy_count = busy_count + CNT_W'(busy[i]);
        end
    end

    assign free_count = CNT_W'(RS_DEPTH) - busy_count;
    assign disp_ready = (free_count != '0);

    always_comb begin
        alloc_idx = '0;
        for (int i = RS_DEPTH-1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // Scanning ports from high to low lets the lowest matching port win.
    always_comb begin
        byp1_hit   = 1'b0;
        byp1_value = '0;
        byp2_hit   = 1'b0;
        byp2_value = '0;
        for (int k = N_CDB-1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == disp_rs1_tag)) begin
                byp1_hit   = 1'b1;
                byp1_value = cdb_value[k*DATA_W +: DATA_W];
            end
            if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == disp_rs2_tag)) begin
                byp2_hit   = 1'b1;
                byp2_value = cdb_value[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            wake1_hit[i]   = 1'b0;
            wake1_value[i] = '0;
            wake2_hit[i]   = 1'b0;
            wake2_value[i] = '0;
            for (int k = N_CDB-1; k >= 0; k--) begin
                if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == entry_rs1_tag[i])) begin
                    wake1_hit[i]   = 1'b1;
                    wake1_value[i] = cdb_value[k*DATA_W +: DATA_W];
                end
                if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == entry_rs2_tag[i])) begin
                    wake2_hit[i]   = 1'b1;
                    wake2_value[i] = cdb_value[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Age wraps naturally in TAG_W bits, so entries just past a ROB wrap still count as young.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            entry_age[i] = entry_rob[i] - rob_head_idx;
            eligible[i]  = busy[i] & entry_rs1_ready[i] & entry_rs2_ready[i];
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (eligible[i] && (!sel_found || (entry_age[i] < best_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = entry_age[i];
            end
        end
    end

    assign iss_valid     = sel_found;
    assign iss_inst      = entry_inst[sel_idx];
    assign iss_rob_idx   = entry_rob[sel_idx];
    assign iss_rs1_value = entry_rs1_value[sel_idx];
    assign iss_rs2_value = entry_rs2_value[sel_idx];

    assign issue_fire = sel_found && iss_ready;
    assign alloc_fire = disp_valid && disp_ready;

    // The allocated slot is never busy, so it cannot collide with a wakeup or the released entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_inst[i]      <= '0;
                entry_rob[i]       <= '0;
                entry_rs1_ready[i] <= 1'b0;
                entry_rs1_tag[i]   <= '0;
                entry_rs1_value[i] <= '0;
                entry_rs2_ready[i] <= 1'b0;
                entry_rs2_tag[i]   <= '0;
                entry_rs2_value[i] <= '0;
            end
        end else if (squash) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy[i] && !entry_rs1_ready[i] && wake1_hit[i]) begin
                    entry_rs1_ready[i] <= 1'b1;
                    entry_rs1_value[i] <= wake1_value[i];
                end
                if (busy[i] && !entry_rs2_ready[i] && wake2_hit[i]) begin
                    entry_rs2_ready[i] <= 1'b1;
                    entry_rs2_value[i] <= wake2_value[i];
                end
            end
            if (issue_fire) begin
                busy[sel_idx] <= 1'b0;
            end
            if (alloc_fire) begin
                busy[alloc_idx]            <= 1'b1;
                entry_inst[alloc_idx]      <= disp_inst;
                entry_rob[alloc_idx]       <= disp_rob_idx;
                entry_rs1_ready[alloc_idx] <= disp_rs1_ready | byp1_hit;
                entry_rs1_tag[alloc_idx]   <= disp_rs1_tag;
                entry_rs1_value[alloc_idx] <= disp_rs1_ready ? disp_rs1_value : byp1_value;
                entry_rs2_ready[alloc_idx] <= disp_rs2_ready | byp2_hit;
                entry_rs2_tag[alloc_idx]   <= disp_rs2_tag;
                entry_rs2_value[alloc_idx] <= disp_rs2_ready ? disp_rs2_value : byp2_value;
            end
        end
    end

endmodule

// File: tb/tb_rs_select_wakeup.sv
// Bench for rs_select_wakeup: directed scenarios followed by random traffic.
// The random traffic is checked against a queue-based reference model.
module tb_rs_select_wakeup;

    localparam int RS_DEPTH = 8;
    localparam int N_CDB    = 2;
    localparam int TAG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int INST_W   = 32;
    localparam int CNT_W    = 4;

    logic                    clock;
    logic                    reset;
    logic                    squash;
    logic                    disp_valid;
    logic                    disp_ready;
    logic [INST_W-1:0]       disp_inst;
    logic [TAG_W-1:0]        disp_rob_idx;
    logic                    disp_rs1_ready;
    logic                    disp_rs2_ready;
    logic [TAG_W-1:0]        disp_rs1_tag;
    logic [TAG_W-1:0]        disp_rs2_tag;
    logic [DATA_W-1:0]       disp_rs1_value;
    logic [DATA_W-1:0]       disp_rs2_value;
    logic [N_CDB-1:0]        cdb_valid;
    logic [N_CDB*TAG_W-1:0]  cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_value;
    logic [TAG_W-1:0]        rob_head_idx;
    logic                    iss_valid;
    logic                    iss_ready;
    logic [INST_W-1:0]       iss_inst;
    logic [TAG_W-1:0]        iss_rob_idx;
    logic [DATA_W-1:0]       iss_rs1_value;
    logic [DATA_W-1:0]       iss_rs2_value;
    logic [CNT_W-1:0]        free_count;

    logic              c_valid [N_CDB];
    logic [TAG_W-1:0]  c_tag   [N_CDB];
    logic [DATA_W-1:0] c_val   [N_CDB];

    assign cdb_valid = {c_valid[1], c_valid[0]};
    assign cdb_tag   = {c_tag[1], c_tag[0]};
    assign cdb_value = {c_val[1], c_val[0]};

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [TAG_W-1:0]  rob;
        logic              r1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] v1;
        logic              r2;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] v2;
    } ent_t;

    ent_t model_q[$];

    rs_select_wakeup #(
        .RS_DEPTH(RS_DEPTH), .N_CDB(N_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .INST_W(INST_W)
    ) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst(disp_inst),
        .disp_rob_idx(disp_rob_idx),
        .disp_rs1_ready(disp_rs1_ready), .disp_rs2_ready(disp_rs2_ready),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_value(disp_rs1_value), .disp_rs2_value(disp_rs2_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rob_head_idx(rob_head_idx),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst(iss_inst),
        .iss_rob_idx(iss_rob_idx), .iss_rs1_value(iss_rs1_value), .iss_rs2_value(iss_rs2_value),
        .free_count(free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset          = 1'b0;
        squash         = 1'b0;
        disp_valid     = 1'b0;
        disp_inst      = '0;
        disp_rob_idx   = '0;
        disp_rs1_ready = 1'b0;
        disp_rs2_ready = 1'b0;
        disp_rs1_tag   = '0;
        disp_rs2_tag   = '0;
        disp_rs1_value = '0;
        disp_rs2_value = '0;
        rob_head_idx   = '0;
        iss_ready      = 1'b0;
        for (int k = 0; k < N_CDB; k++) begin
            c_valid[k] = 1'b0;
            c_tag[k]   = '0;
            c_val[k]   = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_disp(input logic [TAG_W-1:0] rob,
                            input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                            input logic r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
        disp_valid     = 1'b1;
        disp_inst      = 32'hC0DE_0000 | 32'(rob);
        disp_rob_idx   = rob;
        disp_rs1_ready = r1;
        disp_rs1_tag   = t1;
        disp_rs1_value = v1;
        disp_rs2_ready = r2;
        disp_rs2_tag   = t2;
        disp_rs2_value = v2;
    endtask

    task automatic dispatch(input logic [TAG_W-1:0] rob,
                            input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                            input logic r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
        set_disp(rob, r1, t1, v1, r2, t2, v2);
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (free_count !== 4'd8) begin
            miscompares++;
            $display("[TB] FAIL reset_free_count got %0d want 8", free_count);
        end
        vectors++;
        if (disp_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_disp_ready got %b want 1", disp_ready);
        end
        vectors++;
        if (iss_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_iss_valid got %b want 0", iss_valid);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            dispatch(5'(i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i * 3));
            vectors++;
            if (free_count !== 4'(8 - i)) begin
                miscompares++;
                $display("[TB] FAIL fill_free_count step %0d got %0d want %0d", i, free_count, 8 - i);
            end
        end
        vectors++;
        if (disp_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fill_disp_ready got %b want 0", disp_ready);
        end
        dispatch(5'd9, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'd9);
        vectors++;
        if (free_count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL fill_dropped_free_count got %0d want 0", free_count);
        end
        vectors++;
        if (iss_rob_idx !== 5'd1) begin
            miscompares++;
            $display("[TB] FAIL fill_oldest got %0d want 1", iss_rob_idx);
        end
        iss_ready = 1'b1;
        dispatch(5'd20, 1'b1, 5'd0, 32'd20, 1'b1, 5'd0, 32'd20);
        vectors++;
        if (free_count !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL full_release_free_count got %0d want 1", free_count);
        end
        for (int i = 0; i < 7; i++) tick();
        vectors++;
        if (free_count !== 4'd8) begin
            miscompares++;
            $display("[TB] FAIL full_drain_free_count got %0d want 8", free_count);
        end
        iss_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [TAG_W-1:0] order [3];
        order[0] = 5'd31;
        order[1] = 5'd0;
        order[2] = 5'd5;
        do_reset();
        rob_head_idx = 5'd30;
        dispatch(5'd5, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd5);
        dispatch(5'd31, 1'b1, 5'd0, 32'd31, 1'b1, 5'd0, 32'd31);
        dispatch(5'd0, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
        iss_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (iss_valid !== 1'b1 || iss_rob_idx !== order[i]) begin
                miscompares++;
                $display("[TB] FAIL wrap_order slot %0d got valid=%b rob=%0d want rob=%0d",
                         i, iss_valid, iss_rob_idx, order[i]);
            end
            tick();
        end
        vectors++;
        if (iss_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_empty got %b want 0", iss_valid);
        end
        iss_ready = 1'b0;
    endtask

    task automatic test_wakeup();
        do_reset();
        dispatch(5'd3, 1'b0, 5'd1, 32'd0, 1'b1, 5'd0, 32'd7);
        vectors++;
        if (iss_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wakeup_waiting got %b want 0", iss_valid);
        end
        c_valid[1] = 1'b1;
        c_tag[1]   = 5'd1;
        c_val[1]   = 32'd20;
        tick();
        c_valid[1] = 1'b0;
        vectors++;
        if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd3 || iss_rs1_value !== 32'd20 || iss_rs2_value !== 32'd7) begin
            miscompares++;
            $display("[TB] FAIL wakeup_issue got v=%b rob=%0d rs1=%0d rs2=%0d want v=1 rob=3 rs1=20 rs2=7",
                     iss_valid, iss_rob_idx, iss_rs1_value, iss_rs2_value);
        end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        dispatch(5'd4, 1'b1, 5'd0, 32'd11, 1'b0, 5'd9, 32'd0);
        c_valid[0] = 1'b1;
        c_tag[0]   = 5'd9;
        c_val[0]   = 32'd100;
        c_valid[1] = 1'b1;
        c_tag[1]   = 5'd9;
        c_val[1]   = 32'd200;
        tick();
        c_valid[0] = 1'b0;
        c_valid[1] = 1'b0;
        vectors++;
        if (iss_valid !== 1'b1 || iss_rs1_value !== 32'd11 || iss_rs2_value !== 32'd100) begin
            miscompares++;
            $display("[TB] FAIL wakeup_low_port got v=%b rs1=%0d rs2=%0d want v=1 rs1=11 rs2=100",
                     iss_valid, iss_rs1_value, iss_rs2_value);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        set_disp(5'd6, 1'b0, 5'd2, 32'd0, 1'b1, 5'd0, 32'd1);
        c_valid[0] = 1'b1;
        c_tag[0]   = 5'd2;
        c_val[0]   = 32'h55;
        tick();
        disp_valid = 1'b0;
        c_valid[0] = 1'b0;
        vectors++;
        if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd6 || iss_rs1_value !== 32'h55) begin
            miscompares++;
            $display("[TB] FAIL bypass_issue got v=%b rob=%0d rs1=%h want v=1 rob=6 rs1=55",
                     iss_valid, iss_rob_idx, iss_rs1_value);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        dispatch(5'd7, 1'b1, 5'd0, 32'd70, 1'b1, 5'd0, 32'd71);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd7 || free_count !== 4'd7) begin
                miscompares++;
                $display("[TB] FAIL backpressure_hold cycle %0d got v=%b rob=%0d free=%0d want v=1 rob=7 free=7",
                         i, iss_valid, iss_rob_idx, free_count);
            end
            tick();
        end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        vectors++;
        if (iss_valid !== 1'b0 || free_count !== 4'd8) begin
            miscompares++;
            $display("[TB] FAIL backpressure_release got v=%b free=%0d want v=0 free=8", iss_valid, free_count);
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int i = 1; i <= 4; i++) dispatch(5'(i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i));
        vectors++;
        if (free_count !== 4'd4) begin
            miscompares++;
            $display("[TB] FAIL squash_prefill got %0d want 4", free_count);
        end
        squash    = 1'b1;
        iss_ready = 1'b1;
        set_disp(5'd10, 1'b1, 5'd0, 32'd10, 1'b1, 5'd0, 32'd10);
        tick();
        squash     = 1'b0;
        disp_valid = 1'b0;
        vectors++;
        if (free_count !== 4'd8 || iss_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL squash_clear got free=%0d v=%b want free=8 v=0", free_count, iss_valid);
        end
        iss_ready = 1'b0;
        dispatch(5'd12, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2);
        dispatch(5'd13, 1'b0, 5'd3, 32'd0, 1'b1, 5'd0, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (free_count !== 4'd8 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset got free=%0d v=%b dr=%b want free=8 v=0 dr=1",
                     free_count, iss_valid, disp_ready);
        end
    endtask

    // Reference: oldest ready entry by modular distance from the head.
    function automatic int model_select(input logic [TAG_W-1:0] head);
        int best     = -1;
        int best_age = 0;
        for (int i = 0; i < model_q.size(); i++) begin
            int age = (int'(model_q[i].rob) - int'(head) + 32) % 32;
            if (model_q[i].r1 && model_q[i].r2 && (best < 0 || age < best_age)) begin
                best     = i;
                best_age = age;
            end
        end
        return best;
    endfunction

    task automatic cdb_lookup(input logic [TAG_W-1:0] tag, output logic hit, output logic [DATA_W-1:0] val);
        hit = 1'b0;
        val = '0;
        for (int k = 0; k < N_CDB; k++) begin
            if (!hit && c_valid[k] && c_tag[k] == tag) begin
                hit = 1'b1;
                val = c_val[k];
            end
        end
    endtask

    function automatic logic rob_in_use(input logic [TAG_W-1:0] rob);
        for (int i = 0; i < model_q.size(); i++) begin
            if (model_q[i].rob == rob) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic test_random();
        int               sel;
        int               size0;
        int               start;
        logic             hit;
        logic [DATA_W-1:0] val;
        ent_t             e;
        do_reset();
        model_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset     = ($urandom_range(0, 299) == 0);
            squash    = ($urandom_range(0, 79) == 0);
            iss_ready = ($urandom_range(0, 3) != 0);
            rob_head_idx = 5'($urandom_range(0, 31));
            disp_valid = ($urandom_range(0, 9) < 6);
            start = $urandom_range(0, 31);
            disp_rob_idx = 5'(start);
            for (int j = 0; j < 32; j++) begin
                if (!rob_in_use(5'((start + j) % 32))) begin
                    disp_rob_idx = 5'((start + j) % 32);
                    break;
                end
            end
            disp_inst      = $urandom;
            disp_rs1_ready = ($urandom_range(0, 1) == 1);
            disp_rs2_ready = ($urandom_range(0, 1) == 1);
            disp_rs1_tag   = 5'($urandom_range(0, 7));
            disp_rs2_tag   = 5'($urandom_range(0, 7));
            disp_rs1_value = $urandom;
            disp_rs2_value = $urandom;
            for (int k = 0; k < N_CDB; k++) begin
                c_valid[k] = ($urandom_range(0, 2) == 0);
                c_tag[k]   = 5'($urandom_range(0, 7));
                c_val[k]   = $urandom;
            end
            #1;
            sel   = model_select(rob_head_idx);
            size0 = model_q.size();
            vectors++;
            if (free_count !== 4'(RS_DEPTH - size0) || disp_ready !== (size0 < RS_DEPTH)) begin
                miscompares++;
                $display("[TB] FAIL rand_occupancy cyc %0d got free=%0d dr=%b want free=%0d",
                         cyc, free_count, disp_ready, RS_DEPTH - size0);
            end
            vectors++;
            if (iss_valid !== (sel >= 0)) begin
                miscompares++;
                $display("[TB] FAIL rand_iss_valid cyc %0d got %b want %b", cyc, iss_valid, sel >= 0);
            end else if (sel >= 0) begin
                vectors++;
                if (iss_rob_idx !== model_q[sel].rob || iss_inst !== model_q[sel].inst ||
                    iss_rs1_value !== model_q[sel].v1 || iss_rs2_value !== model_q[sel].v2) begin
                    miscompares++;
                    $display("[TB] FAIL rand_iss_data cyc %0d got rob=%0d inst=%h rs1=%h rs2=%h want rob=%0d inst=%h rs1=%h rs2=%h",
                             cyc, iss_rob_idx, iss_inst, iss_rs1_value, iss_rs2_value,
                             model_q[sel].rob, model_q[sel].inst, model_q[sel].v1, model_q[sel].v2);
                end
            end
            if (reset || squash) begin
                model_q.delete();
            end else begin
                for (int i = 0; i < model_q.size(); i++) begin
                    e = model_q[i];
                    if (!e.r1) begin
                        cdb_lookup(e.t1, hit, val);
                        if (hit) begin e.r1 = 1'b1; e.v1 = val; end
                    end
                    if (!e.r2) begin
                        cdb_lookup(e.t2, hit, val);
                        if (hit) begin e.r2 = 1'b1; e.v2 = val; end
                    end
                    model_q[i] = e;
                end
                if (sel >= 0 && iss_ready) model_q.delete(sel);
                if (disp_valid && size0 < RS_DEPTH) begin
                    e.inst = disp_inst;
                    e.rob  = disp_rob_idx;
                    e.t1   = disp_rs1_tag;
                    e.t2   = disp_rs2_tag;
                    cdb_lookup(disp_rs1_tag, hit, val);
                    e.r1 = disp_rs1_ready || hit;
                    e.v1 = disp_rs1_ready ? disp_rs1_value : val;
                    cdb_lookup(disp_rs2_tag, hit, val);
                    e.r2 = disp_rs2_ready || hit;
                    e.v2 = disp_rs2_ready ? disp_rs2_value : val;
                    model_q.push_back(e);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_wrap();
        test_wakeup();
        test_bypass();
        test_backpressure();
        test_squash();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
